// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the CPU MEM
// stage and a burst loader. A streak counter guarantees the CPU one grant
// after every FAIR_N consecutive loader words.
//
// Handshake: a loader word moves on a cycle where ld_valid & ld_ready are both
// high. ld_ready may depend combinationally on ld_valid, so the loader must
// never make ld_valid depend on ld_ready. The CPU side has no valid/ready
// pair: cpu_req is held while cpu_stall is high, and the access completes in
// the first cycle with cpu_stall low.
module dmem_port_arbiter #(
   parameter int unsigned FAIR_N = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,
   output logic        cpu_err,
   input  logic        ld_start,
   input  logic [31:0] ld_base,
   input  logic [7:0]  ld_count,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   output logic        ld_busy,
   output logic        ld_done,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd,
   output logic        dbg_state_o
);

   localparam logic [3:0] FAIR = 4'(FAIR_N);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t      state_q;
   logic [7:0]  ptr_q;
   logic [7:0]  remain_q;
   logic [3:0]  streak_q;
   logic        done_q;

   logic        in_load;
   logic        cpu_grant;
   logic        addr_bad;
   logic        xfer;

   // Only the word index inside the 256-byte window is used from ld_base.
   logic unused_base;
   assign unused_base = ^{ld_base[31:8], ld_base[1:0]};

   // Arbitration: CPU wins in IDLE, and in LOAD when the streak is exhausted
   // or the loader has nothing to offer this cycle.
   always_comb begin
      in_load   = (state_q == LOAD);
      addr_bad  = (cpu_addr[1:0] != 2'b00) || (cpu_addr[31:8] != 24'd0);
      cpu_grant = cpu_req;
      if (in_load) begin
         cpu_grant = cpu_req && ((streak_q == FAIR) || !ld_valid);
      end
      ld_ready  = in_load && !cpu_grant;
      xfer      = ld_valid && ld_ready;
      cpu_stall = cpu_req && !cpu_grant;
      cpu_err   = cpu_grant && addr_bad;
      ld_busy   = in_load;
      ld_done   = done_q;
   end

   // Memory port mux: loader pointer during a transfer or an idle LOAD cycle,
   // CPU address otherwise; writes are blocked while reset is asserted.
   always_comb begin
      mem_a     = cpu_addr;
      mem_wd    = cpu_wdata;
      mem_we    = cpu_grant && cpu_we && !addr_bad;
      cpu_rdata = (cpu_grant && !addr_bad) ? mem_rd : 32'd0;
      if (xfer) begin
         mem_a  = {24'd0, ptr_q};
         mem_wd = ld_data;
         mem_we = 1'b1;
      end else if (in_load && !cpu_grant) begin
         mem_a  = {24'd0, ptr_q};
      end
      if (!rst_n) begin
         mem_we = 1'b0;
      end
   end

   assign dbg_state_o = (state_q == LOAD);

   // Burst sequencer FSM with pointer, remaining count, streak and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= 8'd0;
         remain_q <= 8'd0;
         streak_q <= 4'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ld_start) begin
                  if (ld_count != 8'd0) begin
                     ptr_q    <= {ld_base[7:2], 2'b00};
                     remain_q <= ld_count;
                     streak_q <= 4'd0;
                     state_q  <= LOAD;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  ptr_q    <= ptr_q + 8'd4;
                  remain_q <= remain_q - 8'd1;
                  streak_q <= (streak_q == FAIR) ? FAIR : streak_q + 4'd1;
                  if (remain_q == 8'd1) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end else if (cpu_grant) begin
                  streak_q <= 4'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by random traffic.
// The driver computes expected outputs from a high-level burst/fairness model
// and a reference copy of memory; a monitor compares on the falling edge.
module tb_dmem_port_arbiter;
  localparam int FAIR_N = 4;
  localparam int W = 102;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_err;
  logic [31:0] cpu_rdata;
  logic        ld_start = 1'b0;
  logic [31:0] ld_base = '0;
  logic [7:0]  ld_count = '0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_ready, ld_busy, ld_done;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic        dbg_state;

  dmem_port_arbiter #(.FAIR_N(FAIR_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .dbg_state_o(dbg_state)
  );

  // clock / environment memory
  always #5 clk = ~clk;

  logic [31:0] env_mem [64];
  assign mem_rd = env_mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_a[7:2]] <= mem_wd;
  end

  // reference model state
  logic [31:0] ref_mem [64];
  bit  m_on;
  int  m_next, m_left, m_since;
  bit  m_done;
  bit  last_stall;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // driver: one cycle of stimulus plus expected outputs for that cycle
  task automatic step(input logic rst, input logic req, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic start, input logic [31:0] base,
                      input logic [7:0] cnt, input logic valid,
                      input logic [31:0] data);
    bit bad, cpu_ok, take, e_stall, e_err, e_ready, e_busy, e_done, e_we, new_done;
    logic [31:0] e_rdata, e_a, e_wd;
    @(posedge clk); #1;
    rst_n = rst; cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    ld_start = start; ld_base = base; ld_count = cnt; ld_valid = valid; ld_data = data;
    if (!rst) begin
      m_on = 0; m_next = 0; m_left = 0; m_since = 0; m_done = 0;
    end
    bad     = (addr[1:0] != 0) || (addr[31:8] != 0);
    cpu_ok  = m_on ? (req && (m_since >= FAIR_N || !valid)) : req;
    take    = m_on && valid && !cpu_ok;
    e_stall = req && !cpu_ok;
    e_err   = cpu_ok && bad;
    e_rdata = (cpu_ok && !bad) ? ref_mem[addr[7:2]] : 32'd0;
    e_ready = m_on && !cpu_ok;
    e_busy  = m_on;
    e_done  = m_done;
    e_we    = rst && (take || (cpu_ok && we && !bad));
    e_a     = (m_on && !cpu_ok) ? 32'(m_next) : addr;
    e_wd    = take ? data : (e_we ? wd : 32'd0);
    exp_q.push_back({e_stall, e_err, e_rdata, e_ready, e_busy, e_done, e_we, e_a, e_wd});
    last_stall = e_stall;
    new_done = 0;
    if (rst) begin
      if (take) ref_mem[m_next / 4] = data;
      else if (e_we) ref_mem[addr[7:2]] = wd;
      if (!m_on) begin
        if (start) begin
          if (cnt == 0) new_done = 1;
          else begin
            m_on = 1; m_next = int'(base % 256) / 4 * 4; m_left = cnt; m_since = 0;
          end
        end
      end else if (take) begin
        m_next = (m_next + 4) % 256;
        m_left = m_left - 1;
        m_since = m_since + 1;
        if (m_left == 0) begin m_on = 0; new_done = 1; end
      end else if (cpu_ok) begin
        m_since = 0;
      end
    end
    m_done = new_done;
  endtask

  task automatic cpu(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    step(1, 1, we, addr, wd, 0, 0, 0, 0, 0);
  endtask
  task automatic start_burst(input logic [31:0] base, input logic [7:0] cnt);
    step(1, 0, 0, 0, 0, 1, base, cnt, 0, 0);
  endtask
  task automatic ld(input logic valid, input logic req, input logic [31:0] data);
    step(1, req, 0, 32'h20, 0, 0, 0, 0, valid, data);
  endtask
  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_stall", 32'(cpu_stall), 32'(e[101]));
        chk("cpu_err",   32'(cpu_err),   32'(e[100]));
        chk("cpu_rdata", cpu_rdata,      e[99:68]);
        chk("ld_ready",  32'(ld_ready),  32'(e[67]));
        chk("ld_busy",   32'(ld_busy),   32'(e[66]));
        chk("ld_done",   32'(ld_done),   32'(e[65]));
        chk("mem_we",    32'(mem_we),    32'(e[64]));
        chk("mem_a",     mem_a,          e[63:32]);
        if (e[64]) chk("mem_wd", mem_wd, e[31:0]);
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] r_addr, r_wd;
    logic r_req, r_we;
    for (int i = 0; i < 64; i++) begin env_mem[i] = 0; ref_mem[i] = 0; end
    // reset
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    // idle CPU write then read
    cpu(1, 32'h10, 32'hDEADBEEF);
    cpu(0, 32'h10, 0);
    nop();
    // burst of 3 at 0x20
    start_burst(32'h20, 3);
    ld(1, 0, 32'h11); ld(1, 0, 32'h22); ld(1, 0, 32'h33);
    nop();
    cpu(0, 32'h24, 0);
    // zero-length burst
    start_burst(32'h80, 0);
    nop();
    // fairness: 10 words against a continuously requesting CPU
    start_burst(32'h40, 10);
    for (int i = 0; i < 12; i++) ld(1, 1, 32'h100 + i);
    nop();
    // gap reuse
    start_burst(32'hA0, 3);
    ld(1, 0, 32'hA1); ld(0, 1, 0); ld(1, 1, 32'hA2); ld(1, 1, 32'hA3); ld(0, 1, 0);
    nop();
    // wrap and error
    start_burst(32'h1FD, 2);
    ld(1, 0, 32'hF0F0); ld(1, 0, 32'h0F0F);
    cpu(0, 32'hFC, 0); cpu(0, 32'h0, 0);
    cpu(0, 32'h102, 0); cpu(1, 32'h102, 32'h5);
    // reset mid-burst
    start_burst(32'h60, 5);
    ld(1, 0, 32'h61); ld(1, 0, 32'h62);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h63);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h64);
    step(1, 1, 0, 32'h60, 0, 0, 0, 0, 1, 32'h65);
    nop(); nop();
    // random traffic; stalled CPU requests are held unchanged
    r_req = 0; r_we = 0; r_addr = 0; r_wd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        r_req = ($urandom_range(0, 2) != 0);
        r_we = $urandom_range(0, 1) == 1;
        r_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63) * 4);
        r_wd = $urandom;
      end
      step(1, r_req, r_we, r_addr, r_wd, $urandom_range(0, 3) == 0, $urandom,
           8'($urandom_range(0, 12)), $urandom_range(0, 3) != 0, $urandom);
    end
    nop();
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
